// File: rtl/acc4_unit.sv
// acc4_unit: 4-bit accumulator with IDLE/EXEC/DONE handshake and a consumed-result counter.
// Optional build macro ACC4_SAT_EN clamps ADD/SUB results on signed overflow.
module acc4_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [3:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       acc,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [3:0]       data_q, data_d;
  logic [3:0]       acc_q, acc_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [3:0]       b_eff_s;
  logic [4:0]       sum_s;
  logic             ovf_raw_s;
  logic [3:0]       res_s;

  // Adder datapath: SUB is acc + ~B + 1, so the carry-in doubles as the subtract flag.
  always_comb begin
    b_eff_s   = (op_q == OP_SUB) ? ~data_q : data_q;
    sum_s     = {1'b0, acc_q} + {1'b0, b_eff_s} + {4'b0000, (op_q == OP_SUB)};
    ovf_raw_s = (acc_q[3] == b_eff_s[3]) && (sum_s[3] != acc_q[3]);
`ifdef ACC4_SAT_EN
    if (ovf_raw_s) begin
      res_s = acc_q[3] ? 4'b1000 : 4'b0111;
    end else begin
      res_s = sum_s[3:0];
    end
`else
    res_s = sum_s[3:0];
`endif
  end

  // Next-state and register-update logic for the three-state handshake.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    acc_d       = acc_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          data_d  = in_data;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_ADD, OP_SUB: begin
            acc_d  = res_s;
            cout_d = sum_s[4];
            ovf_d  = ovf_raw_s;
          end
          OP_LOAD: begin
            acc_d  = data_q;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
          end
          OP_CLEAR: begin
            acc_d  = 4'b0000;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
          end
          default: begin
            acc_d  = acc_q;
            cout_d = cout_q;
            ovf_d  = ovf_q;
          end
        endcase
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // A request arriving with out_ready is not taken here; IDLE accepts it next edge.
        if (out_ready) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'b00;
      data_q      <= 4'b0000;
      acc_q       <= 4'b0000;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      acc_q       <= acc_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc       = acc_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign op_cnt    = cnt_q;
  assign zero      = (acc_q == 4'b0000);
  assign neg       = acc_q[3];

endmodule

// File: tb/tb_acc4_unit.sv
// Self-checking bench for acc4_unit: vector table through a scoreboard queue plus
// hand-written hold, reset-abort and counter-wrap sequences.
module tb_acc4_unit;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [3:0] acc;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_op = 2'b00;
  logic [3:0] in_data = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] acc;
  logic       cout, ovf, zero, neg;
  logic [7:0] op_cnt;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_cnt = 8'd0;
  vec_t       exp_q[$];
  vec_t       tbl[13];

  acc4_unit #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [1:0] op, logic [3:0] d, logic [3:0] a, logic c, logic o);
    vec_t v;
    v.op = op; v.data = d; v.acc = a; v.cout = c; v.ovf = o;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Present one request in IDLE and push its expected result at the accepting edge.
  task automatic issue(input vec_t v);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_op = v.op; in_data = v.data;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(v);
    chk("out_valid_after_accept", out_valid, 0);
    chk("in_ready_after_accept", in_ready, 0);
  endtask

  task automatic wait_and_check();
    vec_t e;
    int cyc;
    @(posedge clk); #1;
    chk("out_valid_latency", out_valid, 1);
    cyc = 0;
    while (!out_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", out_valid, 1);
    end else if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("acc", acc, e.acc);
      chk("cout", cout, e.cout);
      chk("ovf", ovf, e.ovf);
      chk("zero", zero, (e.acc == 4'd0));
      chk("neg", neg, e.acc[3]);
      chk("in_ready_done", in_ready, 0);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk("out_valid_after_consume", out_valid, 0);
    chk("op_cnt", op_cnt, exp_cnt);
  endtask

  initial begin
    tbl[0]  = mk(LOAD, 4'd5,  4'd5,  1'b0, 1'b0);
    tbl[1]  = mk(ADD,  4'd3,  4'd8,  1'b0, 1'b1);
    tbl[2]  = mk(LOAD, 4'd3,  4'd3,  1'b0, 1'b0);
    tbl[3]  = mk(SUB,  4'd3,  4'd0,  1'b1, 1'b0);
    tbl[4]  = mk(SUB,  4'd1,  4'd15, 1'b0, 1'b0);
    tbl[5]  = mk(ADD,  4'd1,  4'd0,  1'b1, 1'b0);
    tbl[6]  = mk(LOAD, 4'd8,  4'd8,  1'b0, 1'b0);
    tbl[7]  = mk(SUB,  4'd1,  4'd7,  1'b1, 1'b1);
    tbl[8]  = mk(CLR,  4'd15, 4'd0,  1'b0, 1'b0);
    tbl[9]  = mk(ADD,  4'd7,  4'd7,  1'b0, 1'b0);
    tbl[10] = mk(ADD,  4'd9,  4'd0,  1'b1, 1'b0);
    tbl[11] = mk(LOAD, 4'd6,  4'd6,  1'b0, 1'b0);
    tbl[12] = mk(SUB,  4'd10, 4'd12, 1'b0, 1'b1);
`ifdef ACC4_SAT_EN
    tbl[1].acc  = 4'd7;
    tbl[7].acc  = 4'd8;
    tbl[12].acc = 4'd7;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", acc, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_op_cnt", op_cnt, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_zero", zero, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      issue(tbl[i]);
      wait_and_check();
      consume();
    end

    // Hold in DONE with in_valid asserted, then release with in_valid still high
    issue(mk(LOAD, 4'd4, 4'd4, 1'b0, 1'b0));
    wait_and_check();
    in_valid = 1'b1; in_op = ADD; in_data = 4'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_acc", acc, 4);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_op_cnt", op_cnt, exp_cnt);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("release_op_cnt", op_cnt, exp_cnt);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(mk(ADD, 4'd1, 4'd5, 1'b0, 1'b0));
    chk("late_accept_in_ready", in_ready, 0);
    wait_and_check();
    consume();

    // Reset asserted mid-EXEC after LOAD 9 accepted
    issue(mk(LOAD, 4'd9, 4'd9, 1'b0, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_acc", acc, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_op_cnt", op_cnt, 0);
    chk("abort_in_ready", in_ready, 1);
    exp_q.delete();
    exp_cnt = 8'd0;
    @(negedge clk);
    chk("abort_acc_held", acc, 0);
    rst_n = 1'b1;

    // 256 CLEARs wrap the 8-bit counter back to zero
    for (int n = 0; n < 256; n++) begin
      issue(mk(CLR, n[3:0], 4'd0, 1'b0, 1'b0));
      wait_and_check();
      consume();
    end
    chk("wrap_op_cnt_zero", op_cnt, 0);

    issue(mk(LOAD, 4'd2, 4'd2, 1'b0, 1'b0));
    wait_and_check();
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
